// File: rtl/vga_prefetch.sv
// Frame prefetcher: streams frame_words consecutive 48-bit SRAM words into a
// small FIFO ahead of the pixel consumer, stalling the reads while the FIFO is full.
module vga_prefetch #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [19:0] base_addr,
    input  logic [19:0] frame_words,
    output logic [19:0] mem_addr,
    output logic        mem_sel,
    input  logic [47:0] mem_data,
    input  logic        mem_valid,
    output logic [47:0] pix_data,
    output logic        pix_empty,
    input  logic        pix_pop,
    output logic        busy,
    output logic        underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STALL, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [19:0]     r_base;
    logic [19:0]     r_words;
    logic [19:0]     r_index;
    logic [19:0]     w_index_inc;
    logic [47:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic [AW:0]     w_count_next;
    logic            r_underflow;
    logic            w_empty;
    logic            w_room;
    logic            w_push;
    logic            w_pop;

    assign w_empty     = (r_count == '0);
    assign w_room      = (r_count != L_FULL);
    assign w_index_inc = r_index + 20'd1;

    // frame_start flushes the FIFO, so a word returning or a pop in that cycle is dropped
    assign w_push = (r_state == S_FETCH) && mem_valid && w_room && !frame_start;
    assign w_pop  = pix_pop && !w_empty && !frame_start;

    assign w_count_next = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: w_state_next = r_state;
            S_FETCH: begin
                if (w_push) begin
                    if (w_index_inc == r_words)
                        w_state_next = S_DONE;
                    else if (w_count_next == L_FULL)
                        w_state_next = S_STALL;
                end
            end
            S_STALL: begin
                if (w_count_next != L_FULL)
                    w_state_next = S_FETCH;
            end
            default: w_state_next = S_IDLE;
        endcase
        if (frame_start)
            w_state_next = (frame_words == '0) ? S_DONE : S_FETCH;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_words     <= '0;
            r_index     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (frame_start) begin
                r_base      <= base_addr;
                r_words     <= frame_words;
                r_index     <= '0;
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_count     <= '0;
                r_underflow <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                    r_index  <= w_index_inc;
                end
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                r_count <= w_count_next;
                if (pix_pop && w_empty)
                    r_underflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: pointers and count define which entries are live
    always_ff @(posedge clk) begin
        if (w_push && !rst)
            r_mem[r_wr_ptr] <= mem_data;
    end

    assign mem_addr  = r_base + r_index;
    assign mem_sel   = (r_state == S_FETCH) && w_room;
    assign pix_data  = r_mem[r_rd_ptr];
    assign pix_empty = w_empty;
    assign busy      = (r_state == S_FETCH) || (r_state == S_STALL);
    assign underflow = r_underflow;

endmodule

// File: tb/tb_vga_prefetch.sv
// Scoreboard bench for vga_prefetch: directed frames, a one-wait-state SRAM model,
// and a monitor that checks every accepted address and every popped word.
module tb_vga_prefetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic [19:0] base_addr = '0;
    logic [19:0] frame_words = '0;
    logic [19:0] mem_addr;
    logic        mem_sel;
    logic [47:0] mem_data;
    logic        mem_valid = 1'b0;
    logic [47:0] pix_data;
    logic        pix_empty;
    logic        pix_pop = 1'b0;
    logic        busy;
    logic        underflow;

    int n_cmp  = 0;
    int n_fail = 0;
    int wait_cnt = 0;

    logic [19:0] exp_addr[$];
    logic [47:0] exp_data[$];

    vga_prefetch #(.DEPTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .base_addr  (base_addr),
        .frame_words(frame_words),
        .mem_addr   (mem_addr),
        .mem_sel    (mem_sel),
        .mem_data   (mem_data),
        .mem_valid  (mem_valid),
        .pix_data   (pix_data),
        .pix_empty  (pix_empty),
        .pix_pop    (pix_pop),
        .busy       (busy),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] dfn(input logic [19:0] a);
        return {8'hC3, a ^ 20'h5A5A5, a};
    endfunction

    // SRAM model: data follows the address; valid one cycle after each new request
    always_comb mem_data = dfn(mem_addr);

    always @(negedge clk) begin
        if (mem_sel && !mem_valid && wait_cnt == 1) begin
            mem_valid = 1'b1;
            wait_cnt  = 0;
        end else begin
            mem_valid = 1'b0;
            wait_cnt  = mem_sel ? 1 : 0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Monitor: samples late in the low phase, when inputs and outputs are settled
    always @(negedge clk) begin
        #3;
        if (!rst && !frame_start) begin
            if (mem_sel && mem_valid) begin
                if (exp_addr.size() == 0) begin
                    check("unexpected_accept", {44'd0, mem_addr}, 64'hFFFFFFFF);
                end else begin
                    logic [19:0] ea;
                    ea = exp_addr.pop_front();
                    $display("accept addr=%05h expect=%05h", mem_addr, ea);
                    check("mem_addr", {44'd0, mem_addr}, {44'd0, ea});
                end
            end
            if (pix_pop && !pix_empty) begin
                if (exp_data.size() == 0) begin
                    check("unexpected_pop", {16'd0, pix_data}, 64'hFFFFFFFF);
                end else begin
                    logic [47:0] ed;
                    ed = exp_data.pop_front();
                    $display("pop data=%012h expect=%012h", pix_data, ed);
                    check("pix_data", {16'd0, pix_data}, {16'd0, ed});
                end
            end
        end
    end

    task automatic start_frame(input logic [19:0] b, input int w);
        exp_addr.delete();
        exp_data.delete();
        for (int i = 0; i < w; i++) begin
            logic [19:0] a;
            a = b + 20'(i);
            exp_addr.push_back(a);
            exp_data.push_back(dfn(a));
        end
        frame_start = 1'b1;
        base_addr   = b;
        frame_words = 20'(w);
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        for (int k = 0; k < maxc && busy; k++)
            tick();
        check("wait_idle_busy", {63'd0, busy}, 64'd0);
    endtask

    task automatic drain(input int maxc);
        for (int k = 0; k < maxc; k++) begin
            if (!busy && pix_empty) break;
            pix_pop = !pix_empty;
            tick();
        end
        pix_pop = 1'b0;
        check("drain_done", {62'd0, busy, pix_empty}, 64'd1);
        check("drain_addr_left", 64'(exp_addr.size()), 64'd0);
        check("drain_data_left", 64'(exp_data.size()), 64'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        check("rst_mem_sel", {63'd0, mem_sel}, 64'd0);
        check("rst_mem_addr", {44'd0, mem_addr}, 64'd0);
        check("rst_pix_empty", {63'd0, pix_empty}, 64'd1);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_underflow", {63'd0, underflow}, 64'd0);

        // Basic frame, no pops until done
        start_frame(20'h00100, 4);
        check("basic_busy", {63'd0, busy}, 64'd1);
        wait_idle(40);
        check("basic_mem_sel", {63'd0, mem_sel}, 64'd0);
        check("basic_addr_left", 64'(exp_addr.size()), 64'd0);
        for (int i = 0; i < 4; i++) begin
            check("basic_not_empty", {63'd0, pix_empty}, 64'd0);
            pix_pop = 1'b1;
            tick();
        end
        pix_pop = 1'b0;
        check("basic_empty_after4", {63'd0, pix_empty}, 64'd1);
        check("basic_no_underflow", {63'd0, underflow}, 64'd0);

        // Address wrap with a concurrently draining consumer
        start_frame(20'hFFFFE, 4);
        drain(80);

        // Backpressure: FIFO fills, fetch stalls, one pop resumes it
        start_frame(20'h02000, 40);
        repeat (45) tick();
        check("bp_busy", {63'd0, busy}, 64'd1);
        check("bp_stall_sel", {63'd0, mem_sel}, 64'd0);
        check("bp_accepted16", 64'(exp_addr.size()), 64'd24);
        pix_pop = 1'b1;
        tick();
        pix_pop = 1'b0;
        check("bp_resume_sel", {63'd0, mem_sel}, 64'd1);
        check("bp_resume_addr", {44'd0, mem_addr}, 64'h02010);
        drain(400);

        // Underflow: pop while empty, sticky until the next frame_start
        pix_pop = 1'b1;
        tick();
        pix_pop = 1'b0;
        check("uf_set", {63'd0, underflow}, 64'd1);
        check("uf_empty", {63'd0, pix_empty}, 64'd1);
        tick();
        check("uf_sticky", {63'd0, underflow}, 64'd1);
        start_frame(20'h00300, 0);
        check("uf_cleared", {63'd0, underflow}, 64'd0);
        check("zero_frame_busy", {63'd0, busy}, 64'd0);
        check("zero_frame_sel", {63'd0, mem_sel}, 64'd0);
        check("zero_frame_empty", {63'd0, pix_empty}, 64'd1);

        // Restart on the mem_valid cycle of word 5, with a coincident pop
        start_frame(20'h00400, 8);
        begin
            int k;
            for (k = 0; k < 60; k++) begin
                if (exp_addr.size() == 3 && mem_valid) break;
                tick();
            end
            check("restart_reached", 64'(k < 60), 64'd1);
        end
        check("restart_word5_addr", {44'd0, mem_addr}, 64'h00405);
        pix_pop = 1'b1;
        start_frame(20'h00500, 2);
        pix_pop = 1'b0;
        check("restart_empty", {63'd0, pix_empty}, 64'd1);
        check("restart_addr", {44'd0, mem_addr}, 64'h00500);
        check("restart_sel", {63'd0, mem_sel}, 64'd1);
        drain(60);

        // Reset mid-frame with 3 words queued
        start_frame(20'h00600, 10);
        begin
            int k;
            for (k = 0; k < 60; k++) begin
                if (exp_addr.size() == 7) break;
                tick();
            end
            check("rstmid_reached", 64'(k < 60), 64'd1);
        end
        check("rstmid_queued", {63'd0, pix_empty}, 64'd0);
        check("rstmid_fetching", {63'd0, mem_sel}, 64'd1);
        rst = 1'b1;
        exp_addr.delete();
        exp_data.delete();
        tick();
        rst = 1'b0;
        check("rstmid_sel", {63'd0, mem_sel}, 64'd0);
        check("rstmid_empty", {63'd0, pix_empty}, 64'd1);
        check("rstmid_busy", {63'd0, busy}, 64'd0);
        repeat (4) tick();
        check("rstmid_stays_idle", {62'd0, busy, mem_sel}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
